// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end.
// Drives the fetch PC to a 1-cycle synchronous instruction memory, tags the
// returned word with its PC, and buffers it in a 2-entry queue that feeds
// decode over valid/ready. A redirect from execute flushes every wrong-path
// fetch and restarts at the aligned target.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        id_ready
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_ent_t;

  logic [31:0]      fpc_q;     // next fetch PC
  logic             req_v_q;   // a read is in flight, data arrives this cycle
  logic [31:0]      req_pc_q;  // PC of the in-flight read
  fetch_ent_t [1:0] buf_q;     // entry 0 is always the head
  logic [1:0]       cnt_q;

  logic [31:0] redir_pc;
  logic        pop;
  logic        push;
  logic        issue;
  logic [2:0]  occ;
  fetch_ent_t  rsp;

  assign redir_pc = {redirect_pc[31:2], 2'b00};
  assign rsp      = '{pc: req_pc_q, instr: imem_instr};

  // Outputs, handshake and issue decision. Reset gates the outputs so the
  // reset cycle shows a clean, idle interface even mid-operation.
  always_comb begin
    if_valid = !rst && (cnt_q != 2'd0) && !redirect_valid;
    if_pc    = rst ? 32'h0 : buf_q[0].pc;
    if_instr = rst ? 32'h0 : buf_q[0].instr;
    imem_pc  = rst ? RESET_PC : (redirect_valid ? redir_pc : fpc_q);
    pop      = if_valid && id_ready;
    push     = req_v_q && !redirect_valid;
    // Entries that will be held after this edge, counting the in-flight
    // read as already buffered; a new read only fits if at most one remains.
    occ      = {1'b0, cnt_q} + {2'b00, req_v_q} - {2'b00, pop};
    issue    = (occ <= 3'd1);
  end

  // Fetch PC and the single outstanding memory request.
  always_ff @(posedge clk) begin
    if (rst) begin
      fpc_q    <= RESET_PC;
      req_v_q  <= 1'b0;
      req_pc_q <= 32'h0;
    end else if (redirect_valid) begin
      req_v_q  <= 1'b1;
      req_pc_q <= redir_pc;
      fpc_q    <= redir_pc + 32'd4;
    end else begin
      req_v_q <= issue;
      if (issue) begin
        req_pc_q <= fpc_q;
        fpc_q    <= fpc_q + 32'd4;
      end
    end
  end

  // Two-entry shifting queue; head stays in entry 0 so the outputs need no mux.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q <= '0;
      cnt_q <= 2'd0;
    end else if (redirect_valid) begin
      cnt_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          buf_q[cnt_q[0]] <= rsp;
          cnt_q           <= cnt_q + 2'd1;
        end
        2'b01: begin
          buf_q[0] <= buf_q[1];
          cnt_q    <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd2) begin
            buf_q[0] <= buf_q[1];
            buf_q[1] <= rsp;
          end else begin
            buf_q[0] <= rsp;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
